// File: rtl/uart_loader.sv
// uart_loader: host-side command responder (W = write word, R = read word, J = boot) on a byte-wide UART.
// Define UART_LOADER_CHECKSUM_EN to require a trailing XOR byte on every command and on R replies.
module uart_loader #(
  parameter int                TOBITS         = 24,
  parameter logic [TOBITS-1:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter logic [7:0]        ACK            = 8'h06,
  parameter logic [7:0]        NAK            = 8'h15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_q,
  input  logic        rx_dv,
  input  logic        rx_fe,
  output logic        rx_rd,
  output logic [7:0]  tx_d,
  output logic        tx_wr,
  input  logic        tx_thre,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        boot_req,
  output logic [31:0] boot_addr,
  output logic        busy
);

  localparam logic [7:0]        CMD_W  = 8'h57;
  localparam logic [7:0]        CMD_R  = 8'h52;
  localparam logic [7:0]        CMD_J  = 8'h4A;
  localparam logic [TOBITS-1:0] TO_ONE = {{(TOBITS-1){1'b0}}, 1'b1};
  localparam logic [TOBITS-1:0] TO_LAST = TIMEOUT_CYCLES - TO_ONE;

`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CHK, S_MEMWR, S_MEMRD, S_SEND, S_REPLY} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_MEMWR, S_MEMRD, S_SEND, S_REPLY} state_t;
`endif

  state_t            state;
  logic [7:0]        cmd;
  logic [7:0]        rbyte;
  logic [1:0]        cnt;
  logic [2:0]        scnt;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [TOBITS-1:0] to_cnt;
  logic              j_boot;
  logic              boot_pend;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]        chk;
  logic [7:0]        rchk;
`endif

  logic        take;
  logic        can_send;
  logic [31:0] addr_nx;
  logic [31:0] wdata_nx;

  // The rx_rd/tx_wr guards stop a byte being taken or sent twice while the UART core catches up.
  assign take     = rx_dv & ~rx_rd;
  assign can_send = tx_thre & ~tx_wr;
  assign addr_nx  = {rx_q, addr[31:8]};
  assign wdata_nx = {rx_q, wdata[31:8]};
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd       <= 8'h00;
      rbyte     <= 8'h00;
      cnt       <= 2'd0;
      scnt      <= 3'd0;
      addr      <= 32'h0;
      wdata     <= 32'h0;
      rdata     <= 32'h0;
      to_cnt    <= '0;
      j_boot    <= 1'b0;
      boot_pend <= 1'b0;
      rx_rd     <= 1'b0;
      tx_d      <= 8'h00;
      tx_wr     <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      boot_req  <= 1'b0;
      boot_addr <= 32'h0;
`ifdef UART_LOADER_CHECKSUM_EN
      chk       <= 8'h00;
      rchk      <= 8'h00;
`endif
    end else begin
      rx_rd     <= 1'b0;
      tx_wr     <= 1'b0;
      boot_req  <= boot_pend;
      boot_pend <= 1'b0;
      if (boot_pend)
        boot_addr <= addr;

      case (state)
        S_IDLE: begin
          if (take) begin
            rx_rd  <= 1'b1;
            cmd    <= rx_q;
            cnt    <= 2'd0;
            to_cnt <= '0;
            j_boot <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            chk    <= rx_q;
`endif
            if (!rx_fe && (rx_q == CMD_W || rx_q == CMD_R || rx_q == CMD_J)) begin
              state <= S_ADDR;
            end else begin
              rbyte <= NAK;
              state <= S_REPLY;
            end
          end
        end

        S_ADDR: begin
          if (take) begin
            rx_rd  <= 1'b1;
            to_cnt <= '0;
            if (rx_fe) begin
              rbyte <= NAK;
              state <= S_REPLY;
            end else begin
              addr <= addr_nx;
              cnt  <= cnt + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
              chk  <= chk ^ rx_q;
`endif
              if (cnt == 2'd3) begin
                if (cmd == CMD_W) begin
                  state <= S_DATA;
                end else begin
`ifdef UART_LOADER_CHECKSUM_EN
                  state <= S_CHK;
`else
                  if (cmd == CMD_R) begin
                    mem_re   <= 1'b1;
                    mem_addr <= {addr_nx[31:2], 2'b00};
                    state    <= S_MEMRD;
                  end else begin
                    rbyte  <= ACK;
                    j_boot <= 1'b1;
                    state  <= S_REPLY;
                  end
`endif
                end
              end
            end
          end else if (to_cnt == TO_LAST) begin
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end

        S_DATA: begin
          if (take) begin
            rx_rd  <= 1'b1;
            to_cnt <= '0;
            if (rx_fe) begin
              rbyte <= NAK;
              state <= S_REPLY;
            end else begin
              wdata <= wdata_nx;
              cnt   <= cnt + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
              chk   <= chk ^ rx_q;
              if (cnt == 2'd3)
                state <= S_CHK;
`else
              if (cnt == 2'd3) begin
                mem_we    <= 1'b1;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wdata <= wdata_nx;
                state     <= S_MEMWR;
              end
`endif
            end
          end else if (to_cnt == TO_LAST) begin
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end

`ifdef UART_LOADER_CHECKSUM_EN
        // Only a clean byte equal to the running XOR lets the command reach the bus or boot.
        S_CHK: begin
          if (take) begin
            rx_rd  <= 1'b1;
            to_cnt <= '0;
            if (rx_fe || rx_q != chk) begin
              rbyte <= NAK;
              state <= S_REPLY;
            end else if (cmd == CMD_W) begin
              mem_we    <= 1'b1;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= wdata;
              state     <= S_MEMWR;
            end else if (cmd == CMD_R) begin
              mem_re   <= 1'b1;
              mem_addr <= {addr[31:2], 2'b00};
              state    <= S_MEMRD;
            end else begin
              rbyte  <= ACK;
              j_boot <= 1'b1;
              state  <= S_REPLY;
            end
          end else if (to_cnt == TO_LAST) begin
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end
`endif

        S_MEMWR: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            rbyte  <= ACK;
            state  <= S_REPLY;
          end
        end

        S_MEMRD: begin
          if (mem_ready) begin
            mem_re <= 1'b0;
            rdata  <= mem_rdata;
            scnt   <= 3'd0;
`ifdef UART_LOADER_CHECKSUM_EN
            rchk   <= 8'h00;
`endif
            state  <= S_SEND;
          end
        end

        // Shift the read word out LSB first; the checksum build appends the XOR of the four bytes.
        S_SEND: begin
          if (can_send) begin
            tx_wr <= 1'b1;
            tx_d  <= rdata[7:0];
            rdata <= {8'h00, rdata[31:8]};
            scnt  <= scnt + 3'd1;
`ifdef UART_LOADER_CHECKSUM_EN
            rchk  <= rchk ^ rdata[7:0];
            if (scnt == 3'd4) begin
              tx_d  <= rchk;
              state <= S_IDLE;
            end
`else
            if (scnt == 3'd3)
              state <= S_IDLE;
`endif
          end
        end

        S_REPLY: begin
          if (can_send) begin
            tx_wr     <= 1'b1;
            tx_d      <= rbyte;
            boot_pend <= j_boot;
            j_boot    <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: stimulus queues expected tx bytes, bus cycles and boots; negedge monitors pop and compare.
// Also builds with UART_LOADER_CHECKSUM_EN, appending checksum bytes and expecting the extra R reply byte.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_q;
  logic        rx_dv;
  logic        rx_fe;
  logic        rx_rd;
  logic [7:0]  tx_d;
  logic        tx_wr;
  logic        tx_thre;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] rdVal;
  logic        mem_ready;
  logic        boot_req;
  logic [31:0] boot_addr;
  logic        busy;

  always #5 clk = ~clk;

  uart_loader #(.TOBITS(24), .TIMEOUT_CYCLES(24'd200)) dut (
    .clk(clk), .rst(rst), .rx_q(rx_q), .rx_dv(rx_dv), .rx_fe(rx_fe), .rx_rd(rx_rd),
    .tx_d(tx_d), .tx_wr(tx_wr), .tx_thre(tx_thre), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(rdVal), .mem_ready(mem_ready),
    .boot_req(boot_req), .boot_addr(boot_addr), .busy(busy)
  );

  typedef struct {
    logic        isWrite;
    logic [31:0] addr;
    logic [31:0] data;
  } memTxn_t;

  logic [7:0]  txExp[$];
  memTxn_t     memExp[$];
  logic [31:0] bootExp[$];
  logic [7:0]  stimBytes[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastTxCyc = -10;
  int txBusy = 0;
  int memLat = 0;
  bit memStall = 0;
  logic prevWe = 1'b0;
  logic prevRe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input logic [31:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %h", name, actual);
  endtask

  task automatic expectMem(input logic isW, input logic [31:0] a, input logic [31:0] d);
    memTxn_t t;
    t.isWrite = isW;
    t.addr    = a;
    t.data    = d;
    memExp.push_back(t);
  endtask

  // Monitors: TX line model, bus responder and boot observer, all sampled on the falling edge.
  always @(negedge clk) begin
    memTxn_t t;
    if (tx_wr) begin
      checkOutput("tx_thre at write", 32'(tx_thre), 32'd1);
      if (txExp.size() == 0) failNow("tx unexpected", 32'(tx_d));
      else checkOutput("tx byte", 32'(tx_d), 32'(txExp.pop_front()));
      lastTxCyc = cyc;
      txBusy = 3;
      tx_thre = 1'b0;
    end else if (txBusy > 0) begin
      txBusy--;
      if (txBusy == 0) tx_thre = 1'b1;
    end

    if ((mem_we && !prevWe) || (mem_re && !prevRe)) begin
      if (memExp.size() == 0) failNow("mem request unexpected", mem_addr);
      else checkOutput("mem request kind", 32'(mem_we), 32'(memExp[0].isWrite));
    end
    prevWe = mem_we;
    prevRe = mem_re;
    if (mem_ready) begin
      mem_ready = 1'b0;
    end else if ((mem_we || mem_re) && !memStall) begin
      if (memLat < 2) begin
        memLat++;
      end else begin
        memLat = 0;
        mem_ready = 1'b1;
        if (memExp.size() != 0) begin
          t = memExp.pop_front();
          checkOutput("mem addr", mem_addr, t.addr);
          if (t.isWrite) checkOutput("mem wdata", mem_wdata, t.data);
        end
      end
    end

    if (boot_req) begin
      if (bootExp.size() == 0) failNow("boot unexpected", boot_addr);
      else begin
        checkOutput("boot_addr", boot_addr, bootExp.pop_front());
        checkOutput("boot after ack", 32'(cyc), 32'(lastTxCyc + 1));
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input logic fe);
    bit got = 0;
    @(negedge clk);
    rx_q  = b;
    rx_fe = fe;
    rx_dv = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (rx_rd) begin
        got = 1;
        break;
      end
    end
    rx_dv = 1'b0;
    rx_fe = 1'b0;
    if (!got) failNow("rx byte not consumed", 32'(b));
  endtask

  task automatic applyStimulus(input int feIdx, input bit addChk);
    logic [7:0] x = 8'h00;
    foreach (stimBytes[i]) begin
      sendByte(stimBytes[i], i == feIdx);
      x ^= stimBytes[i];
    end
`ifdef UART_LOADER_CHECKSUM_EN
    if (addChk) sendByte(x, 1'b0);
`else
    if (addChk) x = 8'h00;
`endif
  endtask

  task automatic waitIdle(input string name);
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!busy && txExp.size() == 0 && memExp.size() == 0 && bootExp.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) failNow({"idle wait ", name}, 32'(busy));
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    rx_q = 8'h00;
    rx_dv = 1'b0;
    rx_fe = 1'b0;
    tx_thre = 1'b1;
    mem_ready = 1'b0;
    rdVal = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset strobes", {26'h0, rx_rd, tx_wr, mem_we, mem_re, boot_req, busy}, 32'h0);
    checkOutput("reset tx_d", 32'(tx_d), 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    checkOutput("reset boot_addr", boot_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Plain write
    expectMem(1'b1, 32'h00000010, 32'hDEADBEEF);
    txExp.push_back(8'h06);
    stimBytes = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(-1, 1'b1);
    waitIdle("W");

    // Read, reply LSB first
    rdVal = 32'h12345678;
    expectMem(1'b0, 32'h00000010, 32'h0);
    txExp.push_back(8'h78); txExp.push_back(8'h56); txExp.push_back(8'h34); txExp.push_back(8'h12);
`ifdef UART_LOADER_CHECKSUM_EN
    txExp.push_back(8'h08);
`endif
    stimBytes = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
    applyStimulus(-1, 1'b1);
    waitIdle("R");

    // Jump: ACK then boot pulse
    txExp.push_back(8'h06);
    bootExp.push_back(32'h00000100);
    stimBytes = '{8'h4A, 8'h00, 8'h01, 8'h00, 8'h00};
    applyStimulus(-1, 1'b1);
    waitIdle("J");
    checkOutput("boot_addr held", boot_addr, 32'h00000100);

    // Unknown command then an unaligned write
    txExp.push_back(8'h15);
    stimBytes = '{8'h41};
    applyStimulus(-1, 1'b0);
    waitIdle("unknown");
    checkOutput("busy after NAK", 32'(busy), 32'd0);
    expectMem(1'b1, 32'h80000004, 32'h11223344);
    txExp.push_back(8'h06);
    stimBytes = '{8'h57, 8'h07, 8'h00, 8'h00, 8'h80, 8'h44, 8'h33, 8'h22, 8'h11};
    applyStimulus(-1, 1'b1);
    waitIdle("W unaligned");

    // Inter-byte timeout: silent return to IDLE
    stimBytes = '{8'h57, 8'h10};
    applyStimulus(-1, 1'b0);
    repeat (185) @(posedge clk);
    #1;
    checkOutput("busy before timeout", 32'(busy), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("busy after timeout", 32'(busy), 32'd0);

    // Framing error on the third byte
    txExp.push_back(8'h15);
    stimBytes = '{8'h52, 8'h10, 8'h00};
    applyStimulus(2, 1'b0);
    waitIdle("framing");

    // Back-to-back W then R with no gap
    rdVal = 32'hCAFEF00D;
    expectMem(1'b1, 32'h00000040, 32'h55AA0FF0);
    txExp.push_back(8'h06);
    expectMem(1'b0, 32'h00000040, 32'h0);
    txExp.push_back(8'h0D); txExp.push_back(8'hF0); txExp.push_back(8'hFE); txExp.push_back(8'hCA);
`ifdef UART_LOADER_CHECKSUM_EN
    txExp.push_back(8'hC9);
`endif
    stimBytes = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h0F, 8'hAA, 8'h55};
    applyStimulus(-1, 1'b1);
    stimBytes = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h00};
    applyStimulus(-1, 1'b1);
    waitIdle("back-to-back");

`ifdef UART_LOADER_CHECKSUM_EN
    // Wrong checksum byte (correct would be 65)
    txExp.push_back(8'h15);
    stimBytes = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
    applyStimulus(-1, 1'b0);
    waitIdle("bad checksum");
`endif

    // Reset while a write is stalled on the bus
    memStall = 1;
    expectMem(1'b1, 32'h00000020, 32'h01020304);
    stimBytes = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    applyStimulus(-1, 1'b1);
    for (int i = 0; i < 50 && !mem_we; i++) @(posedge clk);
    #1;
    checkOutput("mem_we before reset", 32'(mem_we), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mem_we after reset", 32'(mem_we), 32'd0);
    checkOutput("busy after reset", 32'(busy), 32'd0);
    checkOutput("mem_addr after reset", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    memExp.delete();
    memStall = 0;
    memLat = 0;
    repeat (20) @(posedge clk);

    checkOutput("tx queue drained", 32'(txExp.size()), 32'd0);
    checkOutput("mem queue drained", 32'(memExp.size()), 32'd0);
    checkOutput("boot queue drained", 32'(bootExp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
